opb_single_master: RTL and testbench

//  Single-beat OPB bus initiator: the requesting end of the OPB slave-register protocol.

---
 rtl/opb_single_master.sv | 160 ++++++++++++++++
 tb/tb_opb_single_master.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_single_master.sv
// Single-beat OPB bus initiator: takes one read/write command from fabric
// logic, arbitrates for the OPB, runs one transfer and reports completion.
module opb_single_master #(
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned C_TIMEOUT    = 16,
  parameter int unsigned C_MAX_RETRY  = 8
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rnw,
  input  logic [C_OPB_AWIDTH-1:0] cmd_addr,
  input  logic [3:0]              cmd_be,
  input  logic [C_OPB_DWIDTH-1:0] cmd_data,
  output logic                    rsp_valid,
  output logic [1:0]              rsp_status,
  output logic [C_OPB_DWIDTH-1:0] rsp_data,
  output logic                    M_request,
  input  logic                    OPB_MGrant,
  output logic                    M_select,
  output logic                    M_RNW,
  output logic [0:C_OPB_AWIDTH-1] M_ABus,
  output logic [0:3]              M_BE,
  output logic [0:C_OPB_DWIDTH-1] M_DBus,
  output logic                    M_seqAddr,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_xferAck,
  input  logic                    OPB_errAck,
  input  logic                    OPB_retry,
  input  logic                    OPB_toutSup
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_RSP} state_e;

  typedef enum logic [1:0] {
    RSP_OK         = 2'd0,
    RSP_ERR        = 2'd1,
    RSP_TIMEOUT    = 2'd2,
    RSP_RETRY_FAIL = 2'd3
  } rsp_code_e;

  localparam logic [7:0] TIMER_LAST  = 8'(C_TIMEOUT - 1);
  localparam logic [8:0] RETRY_LIMIT = 9'(C_MAX_RETRY);

  state_e                  state;
  logic                    rnw_q;
  logic [C_OPB_AWIDTH-1:0] addr_q;
  logic [3:0]              be_q;
  logic [C_OPB_DWIDTH-1:0] data_q;
  logic [7:0]              retry_cnt;
  logic [7:0]              timer;

  // No burst support: sequential-address hint is never raised.
  assign M_seqAddr = 1'b0;

  // Command/arbitration/transfer/response sequencer with registered outputs.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_data   <= '0;
      M_request  <= 1'b0;
      M_select   <= 1'b0;
      M_RNW      <= 1'b0;
      M_ABus     <= '0;
      M_BE       <= '0;
      M_DBus     <= '0;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      data_q     <= '0;
      retry_cnt  <= '0;
      timer      <= '0;
    end else begin
      rsp_valid  <= 1'b0;
      rsp_status <= '0;
      rsp_data   <= '0;
      case (state)
        S_IDLE: begin
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            rnw_q     <= cmd_rnw;
            addr_q    <= cmd_addr;
            be_q      <= cmd_be;
            data_q    <= cmd_data;
            retry_cnt <= '0;
            cmd_ready <= 1'b0;
            M_request <= 1'b1;
            state     <= S_REQ;
          end
        end
        S_REQ: begin
          if (OPB_MGrant) begin
            M_request <= 1'b0;
            M_select  <= 1'b1;
            M_RNW     <= rnw_q;
            // cmd_be[3] is byte 0, which is M_BE[0] in OPB numbering
            M_ABus    <= addr_q;
            M_BE      <= be_q;
            M_DBus    <= rnw_q ? '0 : data_q;
            timer     <= '0;
            state     <= S_XFER;
          end
        end
        S_XFER: begin
          if (OPB_errAck || OPB_xferAck) begin
            M_select   <= 1'b0;
            M_RNW      <= 1'b0;
            M_ABus     <= '0;
            M_BE       <= '0;
            M_DBus     <= '0;
            rsp_valid  <= 1'b1;
            rsp_status <= OPB_errAck ? RSP_ERR : RSP_OK;
            // OPB bit 0 is the MSB, so it lands on rsp_data[31]
            rsp_data   <= rnw_q ? OPB_DBus : '0;
            state      <= S_RSP;
          end else if (OPB_retry) begin
            M_select <= 1'b0;
            M_RNW    <= 1'b0;
            M_ABus   <= '0;
            M_BE     <= '0;
            M_DBus   <= '0;
            if ({1'b0, retry_cnt} + 9'd1 >= RETRY_LIMIT) begin
              rsp_valid  <= 1'b1;
              rsp_status <= RSP_RETRY_FAIL;
              state      <= S_RSP;
            end else begin
              retry_cnt <= retry_cnt + 8'd1;
              M_request <= 1'b1;
              state     <= S_REQ;
            end
          end else if (!OPB_toutSup) begin
            if (timer == TIMER_LAST) begin
              M_select   <= 1'b0;
              M_RNW      <= 1'b0;
              M_ABus     <= '0;
              M_BE       <= '0;
              M_DBus     <= '0;
              rsp_valid  <= 1'b1;
              rsp_status <= RSP_TIMEOUT;
              state      <= S_RSP;
            end else begin
              timer <= timer + 8'd1;
            end
          end
        end
        S_RSP: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_opb_single_master.sv
// Bench for opb_single_master: a scripted OPB slave/arbiter drives the bus
// inputs, a transaction-level model predicts each response, and one
// negedge process checks bus outputs every cycle.
module tb_opb_single_master;

  localparam int T_OUT = 16;
  localparam int MAX_R = 8;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rnw = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_be = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic        M_request;
  logic        OPB_MGrant = 1'b0;
  logic        M_select;
  logic        M_RNW;
  logic [0:31] M_ABus;
  logic [0:3]  M_BE;
  logic [0:31] M_DBus;
  logic        M_seqAddr;
  logic [0:31] OPB_DBus = '0;
  logic        OPB_xferAck = 1'b0;
  logic        OPB_errAck = 1'b0;
  logic        OPB_retry = 1'b0;
  logic        OPB_toutSup = 1'b0;

  always #5 OPB_Clk = ~OPB_Clk;

  opb_single_master #(
    .C_OPB_AWIDTH(32),
    .C_OPB_DWIDTH(32),
    .C_TIMEOUT(T_OUT),
    .C_MAX_RETRY(MAX_R)
  ) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw),
    .cmd_addr(cmd_addr), .cmd_be(cmd_be), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_data(rsp_data),
    .M_request(M_request), .OPB_MGrant(OPB_MGrant), .M_select(M_select),
    .M_RNW(M_RNW), .M_ABus(M_ABus), .M_BE(M_BE), .M_DBus(M_DBus),
    .M_seqAddr(M_seqAddr), .OPB_DBus(OPB_DBus), .OPB_xferAck(OPB_xferAck),
    .OPB_errAck(OPB_errAck), .OPB_retry(OPB_retry), .OPB_toutSup(OPB_toutSup)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge OPB_Clk) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  typedef struct {
    logic [1:0]  st;
    logic [31:0] data;
    int          eps;
    int          sel;
    int          lat;
  } rsp_exp_t;

  rsp_exp_t expq[$];

  // Current command, as the bus should carry it while selected.
  logic        exp_rnw = 1'b0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic [3:0]  exp_be = '0;

  // Slave script: grant after g request cycles; retry the first r attempts;
  // on the final attempt hold toutSup for the first s select cycles and
  // answer with kind (0 none, 1 xferAck, 2 errAck, 3 both) at select cycle d.
  int          cfg_g = 0, cfg_r = 0, cfg_s = 0, cfg_d = 0, cfg_kind = 0;
  logic [31:0] cfg_rdata = '0;
  bit          spurious = 1'b0;
  int          retries_done = 0, req_cnt = 0, sel_cnt = 0;

  bit          mon_en = 1'b0;
  logic        prev_req = 1'b0, prev_rsp = 1'b0;
  int          acc_cyc = 0, eps_cnt = 0, sel_tot = 0, rsp_cnt = 0;
  logic [1:0]  last_st = '0;
  logic [31:0] last_data = '0;
  int          last_eps = 0, last_sel = 0, last_lat = 0;

  // Transaction-level prediction from the protocol rules.
  function automatic rsp_exp_t predict(logic rnw, int g, int r, int s, int d,
                                       int kind, logic [31:0] rdata);
    rsp_exp_t p;
    int fin;
    if (r >= MAX_R) begin
      p.st  = 2'd3;
      p.eps = MAX_R;
      p.sel = MAX_R;
    end else begin
      p.eps = r + 1;
      if (kind == 0 || d >= s + T_OUT) begin
        p.st = 2'd2;
        fin  = s + T_OUT;
      end else begin
        p.st = (kind == 1) ? 2'd0 : 2'd1;
        fin  = d + 1;
      end
      p.sel = r + fin;
    end
    p.lat  = p.eps * (g + 1) + p.sel;
    p.data = (rnw && p.st <= 2'd1) ? rdata : 32'h0;
    return p;
  endfunction

  // Per-cycle output check followed by the scripted slave/arbiter response.
  always @(negedge OPB_Clk) begin
    rsp_exp_t e;
    int lat;
    if (mon_en) begin
      chk("seq_addr", 32'(M_seqAddr), 32'd0);
      chk("req_and_sel", 32'(M_request & M_select), 32'd0);
      chk("ready_while_busy", 32'(cmd_ready & (M_request | M_select | rsp_valid)), 32'd0);
      if (M_select) begin
        chk("abus", M_ABus, exp_addr);
        chk("be", 32'(M_BE), 32'(exp_be));
        chk("rnw", 32'(M_RNW), 32'(exp_rnw));
        chk("dbus", M_DBus, exp_rnw ? 32'h0 : exp_data);
      end else begin
        chk("abus_unsel", M_ABus, 32'd0);
        chk("be_unsel", 32'(M_BE), 32'd0);
        chk("rnw_unsel", 32'(M_RNW), 32'd0);
        chk("dbus_unsel", M_DBus, 32'd0);
      end
      if (M_request && !prev_req) eps_cnt++;
      if (M_select) sel_tot++;
      if (rsp_valid) begin
        lat       = cyc - acc_cyc;
        last_st   = rsp_status;
        last_data = rsp_data;
        last_eps  = eps_cnt;
        last_sel  = sel_tot;
        last_lat  = lat;
        chk("rsp_pulse_width", 32'(prev_rsp), 32'd0);
        if (expq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_rsp: rsp_valid=1 status=%0d, required no response", rsp_status);
        end else begin
          e = expq.pop_front();
          chk("rsp_status", 32'(rsp_status), 32'(e.st));
          chk("rsp_data", rsp_data, e.data);
          chk("request_episodes", 32'(eps_cnt), 32'(e.eps));
          chk("select_cycles", 32'(sel_tot), 32'(e.sel));
          chk("latency", 32'(lat), 32'(e.lat));
        end
        rsp_cnt++;
      end else begin
        chk("rsp_data_idle", rsp_data, 32'd0);
      end
      if (cmd_valid && cmd_ready && !OPB_Rst) begin
        acc_cyc = cyc + 1;
        eps_cnt = 0;
        sel_tot = 0;
      end
      prev_req = M_request;
      prev_rsp = rsp_valid;
    end

    OPB_MGrant  = 1'b0;
    OPB_xferAck = 1'b0;
    OPB_errAck  = 1'b0;
    OPB_retry   = 1'b0;
    OPB_toutSup = 1'b0;
    OPB_DBus    = '0;
    if (spurious) begin
      OPB_MGrant  = 1'b1;
      OPB_xferAck = 1'b1;
      OPB_errAck  = 1'b1;
      OPB_retry   = 1'b1;
      OPB_DBus    = '1;
    end else begin
      if (M_request) begin
        OPB_MGrant = (req_cnt >= cfg_g);
        req_cnt++;
      end else begin
        req_cnt = 0;
      end
      if (M_select) begin
        if (retries_done < cfg_r) begin
          if (sel_cnt == 0) begin
            OPB_retry = 1'b1;
            retries_done++;
          end
        end else begin
          OPB_toutSup = (sel_cnt < cfg_s);
          if (cfg_kind != 0 && sel_cnt == cfg_d) begin
            OPB_xferAck = (cfg_kind == 1 || cfg_kind == 3);
            OPB_errAck  = (cfg_kind >= 2);
            OPB_DBus    = cfg_rdata;
          end
        end
        sel_cnt++;
      end else begin
        sel_cnt = 0;
      end
    end
  end

  task automatic do_cmd(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] data, input int g, input int r, input int s,
                        input int d, input int kind, input logic [31:0] rdata,
                        input bit expect_rsp);
    int n;
    int c0;
    cfg_g = g; cfg_r = r; cfg_s = s; cfg_d = d; cfg_kind = kind; cfg_rdata = rdata;
    retries_done = 0;
    exp_rnw = rnw; exp_addr = addr; exp_be = be; exp_data = data;
    if (expect_rsp) expq.push_back(predict(rnw, g, r, s, d, kind, rdata));
    cmd_rnw = rnw; cmd_addr = addr; cmd_be = be; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge OPB_Clk); #1;
      n++;
    end
    if (!cmd_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_wait: cmd_ready=0 after 100 cycles, required 1");
      cmd_valid = 1'b0;
      return;
    end
    c0 = rsp_cnt;
    @(posedge OPB_Clk); #1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    if (expect_rsp) begin
      n = 0;
      while (rsp_cnt == c0 && n < 2000) begin
        @(posedge OPB_Clk); #1;
        n++;
      end
      if (rsp_cnt == c0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_wait: no rsp_valid within 2000 cycles, required one");
      end else begin
        chk("ready_after_rsp", 32'(cmd_ready), 32'd1);
      end
    end
  endtask

  initial begin
    int n;
    repeat (3) @(posedge OPB_Clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_request", 32'(M_request), 32'd0);
    chk("rst_select", 32'(M_select), 32'd0);
    chk("rst_abus", M_ABus, 32'd0);
    chk("rst_dbus", M_DBus, 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_status", 32'(rsp_status), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    mon_en  = 1'b1;
    OPB_Rst = 1'b0;
    @(posedge OPB_Clk); #1;
    chk("ready_after_rst", 32'(cmd_ready), 32'd1);

    // Grant/acks while idle must be ignored.
    spurious = 1'b1;
    repeat (5) begin
      @(posedge OPB_Clk); #1;
      chk("spurious_select", 32'(M_select), 32'd0);
      chk("spurious_request", 32'(M_request), 32'd0);
    end
    spurious = 1'b0;
    @(posedge OPB_Clk); #1;

    // 1: write, immediate grant and ack
    do_cmd(1'b0, 32'h01080E00, 4'hF, 32'hDEADBEEF, 0, 0, 0, 0, 1, 32'h0, 1'b1);
    chk("t1_status", 32'(last_st), 32'd0);
    chk("t1_latency", 32'(last_lat), 32'd2);
    chk("t1_select_cycles", 32'(last_sel), 32'd1);

    // 2: read acked after 3 cycles
    do_cmd(1'b1, 32'h01080E00, 4'hF, 32'h0, 0, 0, 0, 3, 1, 32'h12345678, 1'b1);
    chk("t2_data", last_data, 32'h12345678);
    chk("t2_latency", 32'(last_lat), 32'd5);

    // 3: retry exhaustion, then retry twice and ack, then one below the limit
    do_cmd(1'b1, 32'h00000010, 4'hF, 32'h0, 0, 8, 0, 0, 1, 32'hCAFEF00D, 1'b1);
    chk("t3a_status", 32'(last_st), 32'd3);
    chk("t3a_requests", 32'(last_eps), 32'd8);
    chk("t3a_data", last_data, 32'd0);
    do_cmd(1'b0, 32'h00000014, 4'b1010, 32'h55AA33CC, 0, 2, 0, 0, 1, 32'h0, 1'b1);
    chk("t3b_status", 32'(last_st), 32'd0);
    chk("t3b_requests", 32'(last_eps), 32'd3);
    do_cmd(1'b1, 32'h00000018, 4'b0110, 32'h0, 1, 7, 0, 0, 1, 32'h0BADF00D, 1'b1);
    chk("t3c_status", 32'(last_st), 32'd0);
    chk("t3c_requests", 32'(last_eps), 32'd8);

    // 4: timeout, then timeout suppressed for 100 cycles then ack
    do_cmd(1'b1, 32'h00000020, 4'hF, 32'h0, 0, 0, 0, 0, 0, 32'hFFFFFFFF, 1'b1);
    chk("t4a_status", 32'(last_st), 32'd2);
    chk("t4a_select_cycles", 32'(last_sel), 32'd16);
    chk("t4a_data", last_data, 32'd0);
    do_cmd(1'b0, 32'h00000024, 4'hF, 32'h01020304, 0, 0, 100, 100, 1, 32'h0, 1'b1);
    chk("t4b_status", 32'(last_st), 32'd0);
    chk("t4b_select_cycles", 32'(last_sel), 32'd101);

    // 5: errAck with xferAck, then grant withheld 20 cycles
    do_cmd(1'b1, 32'h00000028, 4'hF, 32'h0, 0, 0, 0, 1, 3, 32'hA5A55A5A, 1'b1);
    chk("t5a_status", 32'(last_st), 32'd1);
    chk("t5a_data", last_data, 32'hA5A55A5A);
    do_cmd(1'b0, 32'h0000002C, 4'h3, 32'h87654321, 20, 0, 0, 0, 1, 32'h0, 1'b1);
    chk("t5b_latency", 32'(last_lat), 32'd22);
    chk("t5b_requests", 32'(last_eps), 32'd1);

    // 6: reset while selected, then a normal command
    do_cmd(1'b1, 32'h01080E04, 4'hF, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1'b0);
    n = 0;
    while (!M_select && n < 20) begin
      @(posedge OPB_Clk); #1;
      n++;
    end
    chk("t6_reached_select", 32'(M_select), 32'd1);
    repeat (2) @(posedge OPB_Clk);
    #1;
    OPB_Rst = 1'b1;
    @(posedge OPB_Clk); #1;
    chk("t6_rst_select", 32'(M_select), 32'd0);
    chk("t6_rst_abus", M_ABus, 32'd0);
    chk("t6_rst_request", 32'(M_request), 32'd0);
    chk("t6_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_rst_cmd_ready", 32'(cmd_ready), 32'd0);
    OPB_Rst = 1'b0;
    repeat (3) @(posedge OPB_Clk);
    #1;
    do_cmd(1'b1, 32'h01080E00, 4'hF, 32'h0, 0, 0, 0, 0, 1, 32'h13579BDF, 1'b1);
    chk("t6_after_status", 32'(last_st), 32'd0);
    chk("t6_after_data", last_data, 32'h13579BDF);

    repeat (5) @(posedge OPB_Clk);
    #1;
    if (expq.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL missing_rsp: %0d responses outstanding, required 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
